outside_uart_lb: RTL and testbench

OUTSIDE_UART_LB -- requirements
Module: outside_uart_lb

---
 rtl/outside_uart_lb_pkg.sv | 43 ++++
 rtl/io_generic_fifo.sv | 62 ++++++
 rtl/outside_uart_lb_tx.sv | 102 ++++++++++
 rtl/outside_uart_lb.sv | 196 +++++++++++++++++++
 tb/tb_outside_uart_lb.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/outside_uart_lb_pkg.sv
// Shared types and constants for the outside_uart_lb loopback UART.
//   rx_state_t / tx_state_t : receive and transmit FSM encodings
//   BIT_CNT_W               : data-bit index width (characters are at most 8 bits)
//   PAR_POL_EVEN/ODD        : parity polarity selector values
//   PARITY_EN               : 1 when OUTSIDE_UART_LB_PARITY_EN is defined
//   parity_bit()            : parity bit for a zero-padded character
package outside_uart_lb_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP1,
        TX_STOP2
    } tx_state_t;

    localparam int unsigned BIT_CNT_W = 3;

    localparam logic PAR_POL_EVEN = 1'b0;
    localparam logic PAR_POL_ODD  = 1'b1;

`ifdef OUTSIDE_UART_LB_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Zero padding does not change the XOR, so narrow characters can be
    // passed zero-extended to 8 bits.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// Generic synchronous FIFO with valid/ready handshakes.
//   clk_i, rst_i (async, active-high), clr_i (sync flush)
//   elements_o : occupancy
//   data_o/valid_o/ready_i : read side (pop when valid_o && ready_i)
//   data_i/valid_i/ready_o : write side (push when valid_i && ready_o)
// BUFFER_DEPTH must be a power of two.
module io_generic_fifo #(
    parameter int DATA_WIDTH   = 32,
    parameter int BUFFER_DEPTH = 16
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            clr_i,
    output logic [$clog2(BUFFER_DEPTH):0]   elements_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    input  logic                            valid_i,
    input  logic [DATA_WIDTH-1:0]           data_i,
    output logic                            ready_o
);

    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);

    logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W:0]        count;
    logic                  push;
    logic                  pop;

    // Full/empty come from registered occupancy only, so a pop in the same
    // cycle never makes room for a push into a full buffer.
    assign ready_o    = (count != (PTR_W+1)'(BUFFER_DEPTH));
    assign valid_o    = (count != '0);
    assign push       = valid_i && ready_o;
    assign pop        = ready_i && valid_o;
    assign data_o     = mem[rd_ptr];
    assign elements_o = count;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= data_i;
    end

endmodule

// File: rtl/outside_uart_lb_tx.sv
// Transmit half of the loopback UART: pops characters from the buffer and
// serialises start, data (LSB first), optional parity and 1 or 2 stop bits.
//   loop_en_i    : allow pops
//   stop2_i      : two stop bits, captured at each pop
//   fifo_valid_i : buffer non-empty;  fifo_data_i : head character
//   fifo_pop_o   : pop strobe (same cycle as fifo_valid_i)
//   uart_tx_o    : serial line, idle high
// Parity bit is emitted only when OUTSIDE_UART_LB_PARITY_EN is defined.
module outside_uart_lb_tx
    import outside_uart_lb_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 loop_en_i,
    input  logic                 stop2_i,
    input  logic                 fifo_valid_i,
    input  logic [DATA_BITS-1:0] fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 uart_tx_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t              tx_state;
    tx_state_t              tx_next;
    logic [CNT_W-1:0]       tx_cnt;
    logic [BIT_CNT_W-1:0]   tx_bit;
    logic [DATA_BITS-1:0]   tx_shift;
    logic                   tx_par;
    logic                   stop2_q;
    logic                   tx_tick;
    logic                   last_stop;

    assign tx_tick   = (tx_cnt == FULL_M1);
    assign last_stop = tx_tick && ((tx_state == TX_STOP1 && !stop2_q) || tx_state == TX_STOP2);
    // Popping in the final stop cycle chains frames with no idle gap.
    assign fifo_pop_o = loop_en_i && fifo_valid_i && (tx_state == TX_IDLE || last_stop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tx_state <= TX_IDLE;
        else        tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (fifo_pop_o) tx_next = TX_START;
            TX_START:  if (tx_tick) tx_next = TX_DATA;
            TX_DATA:   if (tx_tick && tx_bit == LAST_BIT) tx_next = PARITY_EN ? TX_PARITY : TX_STOP1;
            TX_PARITY: if (tx_tick) tx_next = TX_STOP1;
            TX_STOP1: begin
                if (tx_tick) begin
                    if (stop2_q)         tx_next = TX_STOP2;
                    else if (fifo_pop_o) tx_next = TX_START;
                    else                 tx_next = TX_IDLE;
                end
            end
            TX_STOP2:  if (tx_tick) tx_next = fifo_pop_o ? TX_START : TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        uart_tx_o = 1'b1;
        case (tx_state)
            TX_START:  uart_tx_o = 1'b0;
            TX_DATA:   uart_tx_o = tx_shift[0];
            TX_PARITY: uart_tx_o = tx_par;
            default:   uart_tx_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_par   <= 1'b0;
            stop2_q  <= 1'b0;
        end else begin
            if (tx_state == TX_IDLE || tx_tick) tx_cnt <= '0;
            else                                tx_cnt <= tx_cnt + CNT_W'(1);

            if (fifo_pop_o) begin
                tx_shift <= fifo_data_i;
                tx_bit   <= '0;
                stop2_q  <= stop2_i;
                tx_par   <= parity_bit(8'(fifo_data_i), PARITY_ODD != 0);
            end else if (tx_state == TX_DATA && tx_tick) begin
                tx_shift <= tx_shift >> 1;
                tx_bit   <= tx_bit + BIT_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/outside_uart_lb.sv
// Loopback UART for testing an external device: receives characters on
// uart_rx_i, buffers them, and (when loop_en_i) retransmits them on uart_tx_o.
//   clk, rst_n         : clock, async active-low reset
//   uart_rx_i          : serial input (asynchronous, 2-flop synchronised)
//   uart_tx_o          : serial output
//   loop_en_i, stop2_i : retransmit enable, two-stop-bit select
//   rx_data_o          : last accepted character
//   rx_valid_o, rx_frame_err_o, rx_parity_err_o : one-cycle event pulses
//   ovf_cnt_o          : saturating dropped-character count
//   fifo_level_o       : buffer occupancy
// Define OUTSIDE_UART_LB_PARITY_EN to add a parity bit to both directions.
module outside_uart_lb
    import outside_uart_lb_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int FIFO_DEPTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          uart_rx_i,
    output logic                          uart_tx_o,
    input  logic                          loop_en_i,
    input  logic                          stop2_i,
    output logic [DATA_BITS-1:0]          rx_data_o,
    output logic                          rx_valid_o,
    output logic                          rx_frame_err_o,
    output logic                          rx_parity_err_o,
    output logic [7:0]                    ovf_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]     HALF_M1  = CNT_W'(CLKS_PER_BIT/2 - 1);
    localparam logic [CNT_W-1:0]     FULL_M1  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    logic                   rx_meta;
    logic                   rx_s;
    logic                   rx_prev;
    rx_state_t              rx_state;
    rx_state_t              rx_next;
    logic [CNT_W-1:0]       rx_cnt;
    logic [BIT_CNT_W-1:0]   rx_bit;
    logic [DATA_BITS-1:0]   rx_shift;
    logic                   rx_wait_high;
    logic                   rx_tick;
    logic                   rx_accept;
    logic                   rx_ferr;

    logic                   fifo_ready;
    logic                   fifo_valid;
    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx_i;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // The start bit is sampled at its midpoint; every later sample is one
    // full bit period on, so all samples land mid-bit.
    assign rx_tick = (rx_state == RX_START) ? (rx_cnt == HALF_M1) : (rx_cnt == FULL_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_state <= RX_IDLE;
        else        rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START:  if (rx_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:   if (rx_tick && rx_bit == LAST_BIT) rx_next = PARITY_EN ? RX_PARITY : RX_STOP;
            RX_PARITY: if (rx_tick) rx_next = RX_STOP;
            RX_STOP: begin
                // After a framing error stay here until the line recovers.
                if (rx_wait_high) begin
                    if (rx_s) rx_next = RX_IDLE;
                end else if (rx_accept) begin
                    rx_next = RX_IDLE;
                end
            end
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_accept = 1'b0;
        rx_ferr   = 1'b0;
        if (rx_state == RX_STOP && !rx_wait_high && rx_tick) begin
            rx_accept = rx_s;
            rx_ferr   = !rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_cnt         <= '0;
            rx_bit         <= '0;
            rx_shift       <= '0;
            rx_wait_high   <= 1'b0;
            rx_data_o      <= '0;
            rx_valid_o     <= 1'b0;
            rx_frame_err_o <= 1'b0;
        end else begin
            if (rx_state == RX_IDLE || rx_tick) rx_cnt <= '0;
            else                                rx_cnt <= rx_cnt + CNT_W'(1);

            if (rx_state == RX_START) begin
                rx_bit <= '0;
            end else if (rx_state == RX_DATA && rx_tick) begin
                rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                rx_bit   <= rx_bit + BIT_CNT_W'(1);
            end

            if (rx_ferr)                    rx_wait_high <= 1'b1;
            else if (rx_state == RX_IDLE)   rx_wait_high <= 1'b0;

            if (rx_accept) rx_data_o <= rx_shift;
            rx_valid_o     <= rx_accept;
            rx_frame_err_o <= rx_ferr;
        end
    end

`ifdef OUTSIDE_UART_LB_PARITY_EN
    logic rx_par_bad;
    logic rx_perr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_par_bad <= 1'b0;
            rx_perr_q  <= 1'b0;
        end else begin
            if (rx_state == RX_START)
                rx_par_bad <= 1'b0;
            else if (rx_state == RX_PARITY && rx_tick)
                rx_par_bad <= (rx_s != parity_bit(8'(rx_shift), PARITY_ODD != 0));
            rx_perr_q <= rx_accept && rx_par_bad;
        end
    end

    assign rx_parity_err_o = rx_perr_q;
`else
    assign rx_parity_err_o = 1'b0;
`endif

    // A character accepted while the buffer is full is counted and lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_cnt_o <= '0;
        else if (rx_valid_o && !fifo_ready && ovf_cnt_o != 8'hFF)
            ovf_cnt_o <= ovf_cnt_o + 8'd1;
    end

    io_generic_fifo #(
        .DATA_WIDTH   (DATA_BITS),
        .BUFFER_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i      (clk),
        .rst_i      (~rst_n),
        .clr_i      (1'b0),
        .elements_o (fifo_level_o),
        .data_o     (fifo_rdata),
        .valid_o    (fifo_valid),
        .ready_i    (fifo_pop),
        .valid_i    (rx_valid_o),
        .data_i     (rx_data_o),
        .ready_o    (fifo_ready)
    );

    outside_uart_lb_tx #(
        .DATA_BITS    (DATA_BITS),
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .PARITY_ODD   (PARITY_ODD)
    ) u_tx (
        .clk          (clk),
        .rst_n        (rst_n),
        .loop_en_i    (loop_en_i),
        .stop2_i      (stop2_i),
        .fifo_valid_i (fifo_valid),
        .fifo_data_i  (fifo_rdata),
        .fifo_pop_o   (fifo_pop),
        .uart_tx_o    (uart_tx_o)
    );

endmodule

// File: tb/tb_outside_uart_lb.sv
// Directed self-checking bench for outside_uart_lb with default parameters.
module tb_outside_uart_lb;
    import outside_uart_lb_pkg::*;

    localparam int CPB   = 16;
    localparam int FRAME = PARITY_EN ? 11 : 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rx_i = 1'b1;
    logic       uart_tx_o;
    logic       loop_en_i = 1'b0;
    logic       stop2_i = 1'b0;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_frame_err_o;
    logic       rx_parity_err_o;
    logic [7:0] ovf_cnt_o;
    logic [3:0] fifo_level_o;

    outside_uart_lb #(
        .DATA_BITS    (8),
        .FIFO_DEPTH   (8),
        .CLKS_PER_BIT (CPB),
        .PARITY_ODD   (0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .uart_rx_i       (uart_rx_i),
        .uart_tx_o       (uart_tx_o),
        .loop_en_i       (loop_en_i),
        .stop2_i         (stop2_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_parity_err_o (rx_parity_err_o),
        .ovf_cnt_o       (ovf_cnt_o),
        .fifo_level_o    (fifo_level_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Observation records filled by the monitors below.
    logic [7:0] rx_q[$];
    logic [8:0] tx_q[$];
    int         tx_fall_q[$];
    logic       tx_par_q[$];
    int         ferr_cnt = 0;
    int         perr_cnt = 0;
    int         perr_with_valid = 0;
    int         last_valid_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] lvl_after_valid = '0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_valid) lvl_after_valid = fifo_level_o;
            prev_valid = rx_valid_o;
            if (rx_valid_o) begin
                rx_q.push_back(rx_data_o);
                last_valid_cyc = cyc;
            end
            if (rx_frame_err_o) ferr_cnt++;
            if (rx_parity_err_o) begin
                perr_cnt++;
                if (rx_valid_o) perr_with_valid++;
            end
        end
    end

    // Decodes frames on uart_tx_o by sampling mid-bit.
    initial begin
        int         fc;
        logic [7:0] d;
        logic       p;
        logic       s;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx_o === 1'b0) begin
                fc = cyc;
                repeat (CPB/2 - 1) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    d[i] = uart_tx_o;
                end
                p = 1'b0;
                if (PARITY_EN) begin
                    repeat (CPB) @(negedge clk);
                    p = uart_tx_o;
                end
                repeat (CPB) @(negedge clk);
                s = uart_tx_o;
                tx_q.push_back({s, d});
                tx_fall_q.push_back(fc);
                tx_par_q.push_back(p);
            end
        end
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_flip);
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx_i = d[i];
            repeat (CPB) @(negedge clk);
        end
        if (PARITY_EN) begin
            uart_rx_i = (^d) ^ par_flip;
            repeat (CPB) @(negedge clk);
        end
        uart_rx_i = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx_i = 1'b1;
    endtask

    task automatic clear_obs();
        rx_q.delete();
        tx_q.delete();
        tx_fall_q.delete();
        tx_par_q.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL reset_tx got %b exp 1", uart_tx_o); end
        checks++; if (rx_data_o !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h exp 00", rx_data_o); end
        checks++; if ({rx_valid_o, rx_frame_err_o, rx_parity_err_o} !== 3'b000) begin errors++; $display("FAIL reset_pulses got %b exp 000", {rx_valid_o, rx_frame_err_o, rx_parity_err_o}); end
        checks++; if (ovf_cnt_o !== 8'd0) begin errors++; $display("FAIL reset_ovf got %0d exp 0", ovf_cnt_o); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", fifo_level_o); end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic();
        clear_obs();
        loop_en_i = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        checks++; if (rx_q.size() != 1) begin errors++; $display("FAIL basic_rx_count got %0d exp 1", rx_q.size()); end
        checks++; if (rx_q[0] !== 8'hA5) begin errors++; $display("FAIL basic_rx_data got %h exp a5", rx_q[0]); end
        checks++; if (rx_data_o !== 8'hA5) begin errors++; $display("FAIL basic_rx_data_o got %h exp a5", rx_data_o); end
        checks++; if (lvl_after_valid !== 4'd1) begin errors++; $display("FAIL basic_level_push got %0d exp 1", lvl_after_valid); end
        checks++; if (tx_q.size() != 1) begin errors++; $display("FAIL basic_tx_count got %0d exp 1", tx_q.size()); end
        checks++; if (tx_q[0] !== 9'h1A5) begin errors++; $display("FAIL basic_tx_frame got %h exp 1a5", tx_q[0]); end
        checks++; if (tx_fall_q[0] != last_valid_cyc + 2) begin errors++; $display("FAIL basic_tx_latency got %0d exp %0d", tx_fall_q[0], last_valid_cyc + 2); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL basic_level_end got %0d exp 0", fifo_level_o); end
    endtask

    task automatic test_glitch();
        int f0;
        int p0;
        clear_obs();
        f0 = ferr_cnt;
        p0 = perr_cnt;
        @(negedge clk);
        uart_rx_i = 1'b0;
        repeat (5) @(negedge clk);
        uart_rx_i = 1'b1;
        repeat (60) @(negedge clk);
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL glitch_valid got %0d exp 0", rx_q.size()); end
        checks++; if (ferr_cnt != f0 || perr_cnt != p0) begin errors++; $display("FAIL glitch_errs got %0d/%0d exp %0d/%0d", ferr_cnt, perr_cnt, f0, p0); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", fifo_level_o); end
    endtask

    task automatic test_frame_err();
        int f0;
        clear_obs();
        loop_en_i = 1'b1;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        checks++; if (ferr_cnt != f0 + 1) begin errors++; $display("FAIL ferr_pulse got %0d exp %0d", ferr_cnt, f0 + 1); end
        checks++; if (rx_q.size() != 0 || fifo_level_o !== 4'd0) begin errors++; $display("FAIL ferr_no_push got %0d/%0d exp 0/0", rx_q.size(), fifo_level_o); end
        send_frame(8'h11, 1'b1, 1'b0);
        repeat (200) @(negedge clk);
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h11) begin errors++; $display("FAIL ferr_next_rx got %0d:%h exp 1:11", rx_q.size(), rx_q[0]); end
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 9'h111) begin errors++; $display("FAIL ferr_next_tx got %0d:%h exp 1:111", tx_q.size(), tx_q[0]); end
    endtask

    task automatic test_overflow();
        int bad;
        clear_obs();
        loop_en_i = 1'b0;
        for (int i = 0; i < 10; i++) send_frame(8'h30 + 8'(i), 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        checks++; if (rx_q.size() != 10) begin errors++; $display("FAIL ovf_rx_count got %0d exp 10", rx_q.size()); end
        checks++; if (fifo_level_o !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", fifo_level_o); end
        checks++; if (ovf_cnt_o !== 8'd2) begin errors++; $display("FAIL ovf_count got %0d exp 2", ovf_cnt_o); end
        loop_en_i = 1'b1;
        repeat (8*FRAME*CPB + 200) @(negedge clk);
        checks++; if (tx_q.size() != 8) begin errors++; $display("FAIL ovf_tx_count got %0d exp 8", tx_q.size()); end
        for (int i = 0; i < 8; i++) begin
            checks++; if (tx_q[i] !== {1'b1, 8'h30 + 8'(i)}) begin errors++; $display("FAIL ovf_tx_order[%0d] got %h exp %h", i, tx_q[i], {1'b1, 8'h30 + 8'(i)}); end
        end
        bad = 0;
        for (int i = 1; i < 8; i++) if (tx_fall_q[i] - tx_fall_q[i-1] != FRAME*CPB) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_spacing got %0d gaps exp 0 (spacing %0d)", bad, FRAME*CPB); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL ovf_drain got %0d exp 0", fifo_level_o); end
    endtask

    task automatic test_stop2();
        clear_obs();
        loop_en_i = 1'b0;
        send_frame(8'h5A, 1'b1, 1'b0);
        send_frame(8'hC3, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        stop2_i = 1'b1;
        loop_en_i = 1'b1;
        repeat (2*(FRAME+1)*CPB + 100) @(negedge clk);
        stop2_i = 1'b0;
        checks++; if (tx_q.size() != 2) begin errors++; $display("FAIL stop2_count got %0d exp 2", tx_q.size()); end
        checks++; if (tx_q[0] !== 9'h15A || tx_q[1] !== 9'h1C3) begin errors++; $display("FAIL stop2_data got %h %h exp 15a 1c3", tx_q[0], tx_q[1]); end
        checks++; if (tx_fall_q[1] - tx_fall_q[0] != (FRAME+1)*CPB) begin errors++; $display("FAIL stop2_spacing got %0d exp %0d", tx_fall_q[1] - tx_fall_q[0], (FRAME+1)*CPB); end
    endtask

    task automatic test_loop_pause();
        clear_obs();
        loop_en_i = 1'b0;
        send_frame(8'h66, 1'b1, 1'b0);
        send_frame(8'h99, 1'b1, 1'b0);
        repeat (10) @(negedge clk);
        loop_en_i = 1'b1;
        repeat (20) @(negedge clk);
        loop_en_i = 1'b0;
        repeat (400) @(negedge clk);
        checks++; if (tx_q.size() != 1 || tx_q[0] !== 9'h166) begin errors++; $display("FAIL pause_tx got %0d:%h exp 1:166", tx_q.size(), tx_q[0]); end
        checks++; if (fifo_level_o !== 4'd1) begin errors++; $display("FAIL pause_level got %0d exp 1", fifo_level_o); end
    endtask

`ifdef OUTSIDE_UART_LB_PARITY_EN
    task automatic test_parity();
        int pv0;
        clear_obs();
        loop_en_i = 1'b1;
        pv0 = perr_with_valid;
        send_frame(8'h07, 1'b1, 1'b1);
        repeat (220) @(negedge clk);
        checks++; if (perr_with_valid != pv0 + 1) begin errors++; $display("FAIL parity_err got %0d exp %0d", perr_with_valid, pv0 + 1); end
        checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'h07) begin errors++; $display("FAIL parity_rx got %0d:%h exp 1:07", rx_q.size(), rx_q[0]); end
        checks++; if (tx_par_q[0] !== 1'b1) begin errors++; $display("FAIL parity_tx_bit got %b exp 1", tx_par_q[0]); end
    endtask
`endif

    task automatic test_reset_mid();
        int sz;
        loop_en_i = 1'b1;
        repeat (40) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checks++; if (uart_tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_tx got %b exp 1", uart_tx_o); end
        checks++; if (fifo_level_o !== 4'd0) begin errors++; $display("FAIL rstmid_level got %0d exp 0", fifo_level_o); end
        checks++; if (ovf_cnt_o !== 8'd0) begin errors++; $display("FAIL rstmid_ovf got %0d exp 0", ovf_cnt_o); end
        rst_n = 1'b1;
        repeat (200) @(negedge clk);
        sz = tx_q.size();
        repeat (300) @(negedge clk);
        checks++; if (tx_q.size() != sz || uart_tx_o !== 1'b1) begin errors++; $display("FAIL rstmid_quiet got %0d frames tx=%b exp %0d frames tx=1", tx_q.size(), uart_tx_o, sz); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_stop2();
        test_loop_pause();
`ifdef OUTSIDE_UART_LB_PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
